// File: rtl/img_pack_dmem_if.sv
// Bundle between the camera/CPU side and the DMEM capture packer.
// Control, pixel stream and DMEM write port travel together; clk/rst stay outside.
interface img_pack_dmem_if #(
  parameter int PXL_W  = 8,
  parameter int WORD_W = 256,
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 10
);
  logic              enable;
  logic              bin_en;
  logic [PXL_W-1:0]  thresh;
  logic              sof;
  logic              pxl_valid;
  logic [PXL_W-1:0]  pxl_data;
  logic              dmem_wren;
  logic [ADDR_W-1:0] dmem_wraddr;
  logic [WORD_W-1:0] dmem_wrdata;
  logic              ccd_done;
  logic              busy;
  logic [CNT_W-1:0]  pxl_cnt;

  modport master (
    output enable, bin_en, thresh, sof, pxl_valid, pxl_data,
    input  dmem_wren, dmem_wraddr, dmem_wrdata, ccd_done, busy, pxl_cnt
  );

  modport slave (
    input  enable, bin_en, thresh, sof, pxl_valid, pxl_data,
    output dmem_wren, dmem_wraddr, dmem_wrdata, ccd_done, busy, pxl_cnt
  );
endinterface

// File: rtl/img_pack_dmem.sv
// Decimating, optionally binarising pixel packer that writes DMEM-width words
// to consecutive addresses and signals completion to the CPU via ccd_done.
module img_pack_dmem #(
  parameter int PXL_W     = 8,
  parameter int WORD_W    = 256,
  parameter int ADDR_W    = 7,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int DS        = 1,
  parameter int BASE_ADDR = 0
) (
  input  logic clk,
  input  logic rst,
  img_pack_dmem_if.slave bus
);
  localparam int PPW    = WORD_W / PXL_W;
  localparam int N      = IMG_W * IMG_H;
  localparam int SRC_W  = IMG_W * DS;
  localparam int SRC_H  = IMG_H * DS;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int COL_W  = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int ROW_W  = (SRC_H > 1) ? $clog2(SRC_H) : 1;
  localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_FLUSH   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              r_state, w_state_nx;
  logic [COL_W-1:0]    r_col, w_col_nx, w_col_b;
  logic [ROW_W-1:0]    r_row, w_row_nx, w_row_b;
  logic [LANE_W-1:0]   r_lane, w_lane_nx, w_lane_b;
  logic [ADDR_W-1:0]   r_widx, w_widx_nx, w_widx_b;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx, w_cnt_b;
  logic [WORD_W-1:0]   r_pack, w_pack_nx, w_pack_b, w_pack_ins;
  logic                r_wren, w_wren_nx;
  logic [ADDR_W-1:0]   r_wraddr, w_wraddr_nx;
  logic [WORD_W-1:0]   r_wrdata, w_wrdata_nx;
  logic                r_done, w_done_nx;
  logic                r_busy, w_busy_nx;
  logic [PXL_W-1:0]    w_pxl;
  logic                w_kept, w_col_wrap, w_last, w_full, w_accept;

  // A sof in ARMED/CAPTURE restarts the frame, so it zeroes the bases the current pixel builds on.
  always_comb begin
    w_col_b  = bus.sof ? '0 : r_col;
    w_row_b  = bus.sof ? '0 : r_row;
    w_lane_b = bus.sof ? '0 : r_lane;
    w_widx_b = bus.sof ? '0 : r_widx;
    w_cnt_b  = bus.sof ? '0 : r_cnt;
    w_pack_b = bus.sof ? '0 : r_pack;
    if (bus.bin_en) begin
      w_pxl = (bus.pxl_data >= bus.thresh) ? {PXL_W{1'b1}} : {PXL_W{1'b0}};
    end else begin
      w_pxl = bus.pxl_data;
    end
    w_pack_ins = w_pack_b;
    w_pack_ins[PXL_W*w_lane_b +: PXL_W] = w_pxl;
    w_kept     = ((32'(w_col_b) % DS) == 0) && ((32'(w_row_b) % DS) == 0);
    w_col_wrap = (w_col_b == COL_W'(SRC_W - 1));
    w_last     = (w_cnt_b == CNT_W'(N - 1));
    w_full     = (w_lane_b == LANE_W'(PPW - 1));
    w_accept   = bus.enable && (((r_state == S_ARMED) && bus.sof) || (r_state == S_CAPTURE));
  end

  // Next-state and registered-output values.
  always_comb begin
    w_state_nx  = r_state;
    w_col_nx    = r_col;
    w_row_nx    = r_row;
    w_lane_nx   = r_lane;
    w_widx_nx   = r_widx;
    w_cnt_nx    = r_cnt;
    w_pack_nx   = r_pack;
    w_wren_nx   = 1'b0;
    w_wraddr_nx = '0;
    w_wrdata_nx = '0;
    case (r_state)
      S_IDLE: begin
        w_state_nx = bus.enable ? S_ARMED : S_IDLE;
      end
      S_ARMED, S_CAPTURE: begin
        if (!bus.enable) begin
          w_state_nx = S_IDLE;
        end else if (w_accept) begin
          w_state_nx = S_CAPTURE;
          w_col_nx   = w_col_b;
          w_row_nx   = w_row_b;
          w_lane_nx  = w_lane_b;
          w_widx_nx  = w_widx_b;
          w_cnt_nx   = w_cnt_b;
          w_pack_nx  = w_pack_b;
          if (bus.pxl_valid) begin
            if (w_col_wrap) begin
              w_col_nx = '0;
              w_row_nx = w_row_b + ROW_W'(1);
            end else begin
              w_col_nx = w_col_b + COL_W'(1);
            end
            if (w_kept) begin
              w_cnt_nx = w_cnt_b + CNT_W'(1);
              // The final pixel emits its word at once so the partial word lands in the FLUSH cycle.
              if (w_full || w_last) begin
                w_wren_nx   = 1'b1;
                w_wraddr_nx = ADDR_W'(BASE_ADDR) + w_widx_b;
                w_wrdata_nx = w_pack_ins;
                w_pack_nx   = '0;
                w_lane_nx   = '0;
                w_widx_nx   = w_widx_b + ADDR_W'(1);
              end else begin
                w_pack_nx = w_pack_ins;
                w_lane_nx = w_lane_b + LANE_W'(1);
              end
              w_state_nx = w_last ? S_FLUSH : S_CAPTURE;
            end else begin
              w_state_nx = S_CAPTURE;
            end
          end else begin
            w_state_nx = S_CAPTURE;
          end
        end else begin
          w_state_nx = r_state;
        end
      end
      S_FLUSH: begin
        w_state_nx = S_DONE;
      end
      S_DONE: begin
        w_state_nx = bus.enable ? S_DONE : S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
    w_busy_nx = (w_state_nx == S_ARMED) || (w_state_nx == S_CAPTURE);
    w_done_nx = (w_state_nx == S_DONE);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Counters, pack register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col    <= '0;
      r_row    <= '0;
      r_lane   <= '0;
      r_widx   <= '0;
      r_cnt    <= '0;
      r_pack   <= '0;
      r_wren   <= 1'b0;
      r_wraddr <= '0;
      r_wrdata <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_col    <= w_col_nx;
      r_row    <= w_row_nx;
      r_lane   <= w_lane_nx;
      r_widx   <= w_widx_nx;
      r_cnt    <= w_cnt_nx;
      r_pack   <= w_pack_nx;
      r_wren   <= w_wren_nx;
      r_wraddr <= w_wraddr_nx;
      r_wrdata <= w_wrdata_nx;
      r_done   <= w_done_nx;
      r_busy   <= w_busy_nx;
    end
  end

  assign bus.dmem_wren   = r_wren;
  assign bus.dmem_wraddr = r_wraddr;
  assign bus.dmem_wrdata = r_wrdata;
  assign bus.ccd_done    = r_done;
  assign bus.busy        = r_busy;
  assign bus.pxl_cnt     = r_cnt;
endmodule

// File: tb/tb_img_pack_dmem.sv
// Scoreboard bench for img_pack_dmem: DS=1 and DS=2 instances, expected
// DMEM writes queued by stimulus and checked by per-instance monitors.
module tb_img_pack_dmem;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  img_pack_dmem_if #(.PXL_W(8), .WORD_W(256), .ADDR_W(7), .CNT_W(10)) b1 ();
  img_pack_dmem_if #(.PXL_W(8), .WORD_W(256), .ADDR_W(7), .CNT_W(10)) b2 ();

  img_pack_dmem #(.DS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  img_pack_dmem #(.DS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct packed {
    logic [6:0]   a;
    logic [255:0] d;
  } wr_t;

  wr_t q1[$];
  wr_t q2[$];
  wr_t e1, e2;
  int  n_tests = 0;
  int  n_fail  = 0;

  // Expected word w of a 784-pixel frame for a given data pattern.
  function automatic logic [255:0] exp_word(input int mode, input int w);
    logic [255:0] r;
    logic [7:0]   v;
    int           k, rr, cc;
    r = '0;
    for (int l = 0; l < 32; l++) begin
      k = 32 * w + l;
      v = 8'h00;
      if (k < 784) begin
        case (mode)
          0: v = 8'(k);
          1: v = (k % 2 == 1) ? 8'hFF : 8'h00;
          2: begin
            rr = 2 * (k / 28);
            cc = 2 * (k % 28);
            v  = 8'(((rr << 4) | (cc & 15)) & 255);
          end
          3: v = 8'hA5;
          default: v = 8'h00;
        endcase
      end
      r[8*l +: 8] = v;
    end
    return r;
  endfunction

  // Source pixel i of a frame with source width src_w.
  function automatic logic [7:0] src_px(input int mode, input int i, input int src_w);
    int row, col;
    row = i / src_w;
    col = i % src_w;
    case (mode)
      0: return 8'(i);
      1: return (i % 2 == 1) ? 8'h80 : 8'h7F;
      2: return 8'((row << 4) | (col & 15));
      3: return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", nm, a, e);
    end
  endtask

  task automatic push_frame(input int which, input int mode, input int nwords);
    wr_t x;
    for (int w = 0; w < nwords; w++) begin
      x.a = 7'(w);
      x.d = exp_word(mode, w);
      if (which == 1) q1.push_back(x);
      else q2.push_back(x);
    end
  endtask

  task automatic drive(input int which, input logic s, input logic v, input logic [7:0] d);
    if (which == 1) begin
      b1.sof = s; b1.pxl_valid = v; b1.pxl_data = d;
    end else begin
      b2.sof = s; b2.pxl_valid = v; b2.pxl_data = d;
    end
    @(negedge clk);
  endtask

  task automatic idle_in(input int which);
    if (which == 1) begin
      b1.sof = 1'b0; b1.pxl_valid = 1'b0; b1.pxl_data = 8'h00;
    end else begin
      b2.sof = 1'b0; b2.pxl_valid = 1'b0; b2.pxl_data = 8'h00;
    end
  endtask

  task automatic set_en(input int which, input logic en);
    if (which == 1) b1.enable = en;
    else b2.enable = en;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int which, input int mode, input int npix, input int src_w, input bit gaps);
    for (int i = 0; i < npix; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) drive(which, 1'b0, 1'b0, 8'h00);
      end
      drive(which, (i == 0), 1'b1, src_px(mode, i, src_w));
    end
  endtask

  task automatic wait_done(input int which, input string nm);
    logic d;
    d = 1'b0;
    for (int c = 0; c < 20 && !d; c++) begin
      d = (which == 1) ? b1.ccd_done : b2.ccd_done;
      if (!d) @(negedge clk);
    end
    chk(nm, 256'(d), 256'(1));
  endtask

  // Scoreboard monitor for the DS=1 instance.
  always @(negedge clk) begin
    if (b1.dmem_wren === 1'b1) begin
      n_tests++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL dut1_unexpected_write addr=%0d data=%h", b1.dmem_wraddr, b1.dmem_wrdata);
      end else begin
        e1 = q1.pop_front();
        if (b1.dmem_wraddr !== e1.a || b1.dmem_wrdata !== e1.d) begin
          n_fail++;
          $display("FAIL dut1_write got addr=%0d data=%h expected addr=%0d data=%h",
                   b1.dmem_wraddr, b1.dmem_wrdata, e1.a, e1.d);
        end
      end
    end
  end

  // Scoreboard monitor for the DS=2 instance.
  always @(negedge clk) begin
    if (b2.dmem_wren === 1'b1) begin
      n_tests++;
      if (q2.size() == 0) begin
        n_fail++;
        $display("FAIL dut2_unexpected_write addr=%0d data=%h", b2.dmem_wraddr, b2.dmem_wrdata);
      end else begin
        e2 = q2.pop_front();
        if (b2.dmem_wraddr !== e2.a || b2.dmem_wrdata !== e2.d) begin
          n_fail++;
          $display("FAIL dut2_write got addr=%0d data=%h expected addr=%0d data=%h",
                   b2.dmem_wraddr, b2.dmem_wrdata, e2.a, e2.d);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    b1.enable = 1'b0; b1.bin_en = 1'b0; b1.thresh = 8'h80;
    b2.enable = 1'b0; b2.bin_en = 1'b0; b2.thresh = 8'h80;
    idle_in(1);
    idle_in(2);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_wren", 256'(b1.dmem_wren), 256'(0));
    chk("rst_wraddr", 256'(b1.dmem_wraddr), 256'(0));
    chk("rst_wrdata", b1.dmem_wrdata, 256'(0));
    chk("rst_done", 256'(b1.ccd_done), 256'(0));
    chk("rst_busy", 256'(b1.busy), 256'(0));
    chk("rst_cnt", 256'(b1.pxl_cnt), 256'(0));

    // Plain frame with exact final-word and done latency.
    push_frame(1, 0, 25);
    set_en(1, 1'b1);
    chk("armed_busy", 256'(b1.busy), 256'(1));
    send(1, 0, 784, 28, 1'b0);
    chk("final_write_t1", 256'(b1.dmem_wren), 256'(1));
    chk("done_low_t1", 256'(b1.ccd_done), 256'(0));
    idle_in(1);
    @(negedge clk);
    chk("done_high_t2", 256'(b1.ccd_done), 256'(1));
    chk("cnt_784", 256'(b1.pxl_cnt), 256'(784));
    chk("done_busy", 256'(b1.busy), 256'(0));
    chk("plain_writes", 256'(q1.size()), 256'(0));
    set_en(1, 1'b0);
    chk("done_drop", 256'(b1.ccd_done), 256'(0));

    // Binarised alternating 0x7F/0x80.
    b1.bin_en = 1'b1;
    b1.thresh = 8'h80;
    push_frame(1, 1, 25);
    set_en(1, 1'b1);
    send(1, 1, 784, 28, 1'b0);
    idle_in(1);
    wait_done(1, "bin_done");
    set_en(1, 1'b0);
    b1.bin_en = 1'b0;

    // Same frame with random valid gaps.
    push_frame(1, 0, 25);
    set_en(1, 1'b1);
    send(1, 0, 784, 28, 1'b1);
    idle_in(1);
    wait_done(1, "gap_done");
    chk("gap_cnt", 256'(b1.pxl_cnt), 256'(784));
    set_en(1, 1'b0);

    // Abort after 100 pixels: three writes and no completion.
    push_frame(1, 0, 3);
    set_en(1, 1'b1);
    send(1, 0, 100, 28, 1'b0);
    idle_in(1);
    b1.enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy", 256'(b1.busy), 256'(0));
    chk("abort_done", 256'(b1.ccd_done), 256'(0));
    chk("abort_writes", 256'(q1.size()), 256'(0));
    send(1, 0, 40, 28, 1'b0);
    idle_in(1);
    repeat (4) @(negedge clk);
    chk("abort_ignored_done", 256'(b1.ccd_done), 256'(0));

    // Restart with sof after 40 pixels of a 0xA5 frame.
    push_frame(1, 3, 1);
    push_frame(1, 0, 25);
    set_en(1, 1'b1);
    send(1, 3, 40, 28, 1'b0);
    send(1, 0, 784, 28, 1'b0);
    idle_in(1);
    wait_done(1, "restart_done");
    chk("restart_writes", 256'(q1.size()), 256'(0));
    set_en(1, 1'b0);

    // Decimation by 2 on a 56x56 source.
    push_frame(2, 2, 25);
    set_en(2, 1'b1);
    send(2, 2, 3136, 56, 1'b0);
    idle_in(2);
    wait_done(2, "ds2_done");
    chk("ds2_cnt", 256'(b2.pxl_cnt), 256'(784));
    chk("ds2_writes", 256'(q2.size()), 256'(0));
    set_en(2, 1'b0);

    repeat (3) @(negedge clk);
    chk("q1_empty", 256'(q1.size()), 256'(0));
    chk("q2_empty", 256'(q2.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
